tdm_demux_4ch: RTL and testbench

Receive end of the 4-channel time-division link whose transmit end is the 4:1 mux, selected by {S1,S0}. A serial beat stream carries the four channels in slot order 0,1,2,3. The block tracks the slot position with an internal 2-bit slot counter. Each completed frame is delivered to four registered channel outputs simultaneously. Frame alignment comes from a frame_start marker, with lock tracking and resync on misalignment.

---
 rtl/tdm_demux_4ch.sv | 184 ++++++++++++++++++
 tb/tb_tdm_demux_4ch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_4ch
// Description : Receive end of a 4-slot time-division link. Serial beats are
//               collected in slot order 0..3 into shadow registers and, once
//               slot 3 arrives, the whole frame is published to ch0..ch3 on
//               the same edge. Frame alignment follows frame_start; a
//               misaligned marker resynchronises, and two misaligned markers
//               without a completed frame between them drop the lock.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               din, din_valid     - serial beat and its qualifier
//               frame_start        - marks the current valid beat as slot 0
//               ch0..ch3           - last complete frame (registered)
//               sel                - slot expected for the next valid beat
//               locked             - high while frame alignment is held
//               frame_valid        - 1-cycle pulse, ch0..ch3 just updated
//               sync_err           - 1-cycle pulse, frame_start at slot != 0
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_4ch #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             frame_valid,
    output logic             sync_err
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [1:0]       r_slot;
    // Set by a sync error; a second sync error while set drops the lock.
    logic             r_err_pend;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;
    logic [WIDTH-1:0] r_ch0;
    logic [WIDTH-1:0] r_ch1;
    logic [WIDTH-1:0] r_ch2;
    logic [WIDTH-1:0] r_ch3;
    logic             r_frame_valid;
    logic             r_sync_err;

    // ------------------------------------------------------------------------
    // Next-state decisions
    // ------------------------------------------------------------------------
    logic [0:0] w_state_nxt;
    logic [1:0] w_slot_nxt;
    logic       w_err_pend_nxt;
    logic       w_wr_en;     // capture din into a shadow register
    logic [1:0] w_wr_idx;    // which shadow register (0..2)
    logic       w_complete;  // slot-3 beat closes a frame
    logic       w_sync_err;  // frame_start seen away from slot 0

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_slot     <= 2'd0;
            r_err_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot     <= w_slot_nxt;
            r_err_pend <= w_err_pend_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_slot_nxt     = r_slot;
        w_err_pend_nxt = r_err_pend;
        w_wr_en        = 1'b0;
        w_wr_idx       = r_slot;
        w_complete     = 1'b0;
        w_sync_err     = 1'b0;

        if (din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (frame_start) begin
                        w_wr_en        = 1'b1;
                        w_wr_idx       = 2'd0;
                        w_slot_nxt     = 2'd1;
                        w_state_nxt    = ST_LOCKED;
                        w_err_pend_nxt = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (frame_start && (r_slot != 2'd0)) begin
                        w_sync_err = 1'b1;
                        if (r_err_pend) begin
                            // Second misalignment with no good frame between.
                            w_state_nxt    = ST_HUNT;
                            w_slot_nxt     = 2'd0;
                            w_err_pend_nxt = 1'b0;
                        end else begin
                            // Resync: this beat becomes slot 0 of a new frame.
                            w_err_pend_nxt = 1'b1;
                            w_wr_en        = 1'b1;
                            w_wr_idx       = 2'd0;
                            w_slot_nxt     = 2'd1;
                        end
                    end else if (r_slot == 2'd3) begin
                        w_complete     = 1'b1;
                        w_slot_nxt     = 2'd0;
                        w_err_pend_nxt = 1'b0;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_wr_idx   = r_slot;
                        w_slot_nxt = r_slot + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: shadow capture, frame publish and status pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh0         <= '0;
            r_sh1         <= '0;
            r_sh2         <= '0;
            r_ch0         <= '0;
            r_ch1         <= '0;
            r_ch2         <= '0;
            r_ch3         <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= w_complete;
            r_sync_err    <= w_sync_err;
            if (w_wr_en) begin
                case (w_wr_idx)
                    2'd0:    r_sh0 <= din;
                    2'd1:    r_sh1 <= din;
                    2'd2:    r_sh2 <= din;
                    default: r_sh0 <= r_sh0;
                endcase
            end
            // Slot 3 goes straight from din so the whole frame lands at once.
            if (w_complete) begin
                r_ch0 <= r_sh0;
                r_ch1 <= r_sh1;
                r_ch2 <= r_sh2;
                r_ch3 <= din;
            end
        end
    end

    // Output logic
    always_comb begin
        sel         = r_slot;
        locked      = (r_state == ST_LOCKED);
        ch0         = r_ch0;
        ch1         = r_ch1;
        ch2         = r_ch2;
        ch3         = r_ch3;
        frame_valid = r_frame_valid;
        sync_err    = r_sync_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_4ch.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux_4ch
// Description : Self-checking bench for tdm_demux_4ch (WIDTH=4). Stimulus
//               drives beats and updates a frame-list reference model; the
//               model pushes expected frame / sync-error events into a queue
//               that a negedge monitor pops whenever the DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_4ch;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic [1:0]   sel;
    logic         locked, frame_valid, sync_err;

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .sel         (sel),
        .locked      (locked),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_sync;
        logic [4*W-1:0] data;   // {ch3,ch2,ch1,ch0}
    } ev_t;

    ev_t          exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           mon_en   = 1'b0;
    int           n_frames = 0;

    // Reference model: list of beats of the frame being assembled.
    logic [W-1:0]   m_frame[$];
    bit             m_locked = 1'b0;
    bit             m_err    = 1'b0;
    logic [4*W-1:0] exp_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        m_locked = 1'b0;
        m_err    = 1'b0;
        exp_last = '0;
    endtask

    task automatic model_step(input bit v, input bit fs, input logic [W-1:0] d);
        ev_t e;
        if (!v) return;
        if (!m_locked) begin
            if (fs) begin
                m_frame.delete();
                m_frame.push_back(d);
                m_locked = 1'b1;
                m_err    = 1'b0;
            end
        end else if (fs && m_frame.size() != 0) begin
            e.is_sync = 1'b1;
            e.data    = '0;
            exp_q.push_back(e);
            m_frame.delete();
            if (m_err) begin
                m_locked = 1'b0;
                m_err    = 1'b0;
            end else begin
                m_err = 1'b1;
                m_frame.push_back(d);
            end
        end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
                e.is_sync = 1'b0;
                e.data    = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
                exp_q.push_back(e);
                m_frame.delete();
                m_err = 1'b0;
            end
        end
    endtask

    task automatic beat(input bit v, input bit fs, input logic [W-1:0] d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        model_step(v, fs, d);
        #1;
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Idle cycle: din and frame_start carry junk that must be ignored.
    task automatic idle();
        beat(1'b0, 1'($urandom_range(0, 1)), W'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops one expected event per DUT pulse, and holds outputs to the
    // last expected frame at all other times.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (frame_valid || sync_err || exp_q.size() != 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {30'd0, frame_valid, sync_err}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_sync) begin
                            chk("sync_err_pulse", {30'd0, frame_valid, sync_err}, 32'd1);
                        end else begin
                            chk("frame_valid_pulse", {30'd0, frame_valid, sync_err}, 32'd2);
                            exp_last = e.data;
                            n_frames++;
                        end
                    end
                end
                chk("ch_outputs", 32'({ch3, ch2, ch1, ch0}), 32'(exp_last));
                chk("sel", 32'(sel), 32'(m_frame.size()));
                chk("locked", 32'(locked), 32'(m_locked));
            end
        end
    end

    initial begin
        int frames_before;
        logic [W-1:0] d;
        bit fs;

        do_reset();
        mon_en = 1'b1;
        idle();
        idle();

        // Directed frame A,B,C,D.
        beat(1, 1, 4'hA);
        beat(1, 0, 4'hB);
        beat(1, 0, 4'hC);
        beat(1, 0, 4'hD);
        idle();
        chk("abcd_frame", 32'({ch3, ch2, ch1, ch0}), 32'h0000DCBA);

        // Exhaustive 1-bit-per-channel patterns, back to back.
        frames_before = n_frames;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                d = '0;
                d[0] = i[k];
                beat(1, k == 0, d);
            end
        end
        idle();
        chk("exhaustive_count", 32'(n_frames - frames_before), 32'd16);

        // Beats in HUNT without frame_start are discarded.
        do_reset();
        beat(1, 0, 4'h5);
        beat(1, 0, 4'h6);
        idle();
        chk("hunt_outputs", 32'({ch3, ch2, ch1, ch0, sel, locked}), 32'd0);

        // Idle gaps inside a frame.
        beat(1, 1, 4'h1);
        beat(1, 0, 4'h2);
        idle(); idle(); idle();
        beat(1, 0, 4'h3);
        beat(1, 0, 4'h4);
        idle();
        chk("gap_frame", 32'({ch3, ch2, ch1, ch0}), 32'h00004321);

        // Misaligned frame_start at slot 2, then recovery.
        beat(1, 1, 4'h7);
        beat(1, 0, 4'h8);
        beat(1, 1, 4'h9);
        beat(1, 0, 4'hA);
        beat(1, 0, 4'hB);
        beat(1, 0, 4'hC);
        idle();
        chk("resync_frame", 32'({ch3, ch2, ch1, ch0}), 32'h0000CBA9);

        // Two misalignments with no frame in between drop the lock.
        beat(1, 1, 4'h1);
        beat(1, 0, 4'h2);
        beat(1, 1, 4'h3);
        beat(1, 0, 4'h4);
        beat(1, 1, 4'h5);
        idle();
        chk("lock_lost", 32'({sel, locked}), 32'd0);

        // Reset mid-frame, then a fresh frame.
        beat(1, 1, 4'hE);
        beat(1, 0, 4'hF);
        do_reset();
        chk("midframe_reset", 32'({ch3, ch2, ch1, ch0, sel, locked}), 32'd0);
        beat(1, 1, 4'h3);
        beat(1, 0, 4'h5);
        beat(1, 0, 4'h7);
        beat(1, 0, 4'h9);
        idle();
        chk("post_reset_frame", 32'({ch3, ch2, ch1, ch0}), 32'h00009753);

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                if (m_frame.size() == 0)
                    fs = ($urandom_range(0, 9) < 8);
                else
                    fs = ($urandom_range(0, 19) == 0);
                beat(1, fs, W'($urandom));
            end
            if (n == 1000) do_reset();
        end
        idle();
        idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
